// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a 3-digit multiplexed 7-segment scan bus.
// Synchronizes and debounces an/seg, decodes digits to BCD and rebuilds whole frames.
module seg_scan_decoder #(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  input  logic        clr_err,
  output logic [11:0] bcd,
  output logic        valid,
  output logic        frame_done,
  output logic        seq_err,
  output logic        seg_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

  typedef enum logic [1:0] {
    WAIT0 = 2'd0,
    GOT0  = 2'd1,
    GOT1  = 2'd2
  } state_t;

  // Returns {unrecognized, nibble}; unknown patterns map to 4'hF.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b0000001: decode_seg = {1'b0, 4'h0};
      7'b1001111: decode_seg = {1'b0, 4'h1};
      7'b0010010: decode_seg = {1'b0, 4'h2};
      7'b0000110: decode_seg = {1'b0, 4'h3};
      7'b1001100: decode_seg = {1'b0, 4'h4};
      7'b0100100: decode_seg = {1'b0, 4'h5};
      7'b0100000: decode_seg = {1'b0, 4'h6};
      7'b0001111: decode_seg = {1'b0, 4'h7};
      7'b0000000: decode_seg = {1'b0, 4'h8};
      7'b0000100: decode_seg = {1'b0, 4'h9};
      default:    decode_seg = {1'b1, 4'hF};
    endcase
  endfunction

  logic [7:0]  an_meta_r, s_an_r;
  logic [6:0]  seg_meta_r, s_seg_r;
  logic [14:0] prev_r;
  logic [7:0]  cnt_r;
  logic        armed_r;
  logic        accept_r;
  logic [7:0]  acc_an_r;
  logic [6:0]  acc_seg_r;
  logic [14:0] cur_s;
  logic        changed_s;
  logic        accept_s;
  logic        blank_s;
  logic        illegal_s;
  logic [1:0]  dig_s;
  logic [4:0]  dec_s;
  state_t      state_r;
  logic [3:0]  sh0_r, sh1_r;

  // Two-flop synchronizer on the asynchronous scan lines.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_meta_r  <= 8'hFF;
      s_an_r     <= 8'hFF;
      seg_meta_r <= 7'h7F;
      s_seg_r    <= 7'h7F;
    end else begin
      an_meta_r  <= an;
      s_an_r     <= an_meta_r;
      seg_meta_r <= seg;
      s_seg_r    <= seg_meta_r;
    end
  end

  // Change detection and the single-shot accept condition.
  always_comb begin
    cur_s     = {s_an_r, s_seg_r};
    changed_s = (cur_s != prev_r);
    accept_s  = armed_r && !changed_s && (cnt_r == CNT_MAX);
  end

  // Stability counter: one accept per steady interval, the captured pair is held for decode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_r    <= {8'hFF, 7'h7F};
      cnt_r     <= 8'd0;
      armed_r   <= 1'b0;
      accept_r  <= 1'b0;
      acc_an_r  <= 8'hFF;
      acc_seg_r <= 7'h7F;
    end else begin
      prev_r   <= cur_s;
      accept_r <= accept_s;
      if (changed_s) begin
        cnt_r   <= 8'd0;
        armed_r <= 1'b1;
      end else begin
        if (cnt_r < CNT_MAX) begin
          cnt_r <= cnt_r + 8'd1;
        end
        if (accept_s) begin
          armed_r <= 1'b0;
        end
      end
      if (accept_s) begin
        {acc_an_r, acc_seg_r} <= cur_s;
      end
    end
  end

  // Digit-strobe classification and segment decode of the accepted pair.
  always_comb begin
    blank_s   = 1'b0;
    illegal_s = 1'b0;
    dig_s     = 2'd0;
    dec_s     = decode_seg(acc_seg_r);
    case (acc_an_r)
      8'hFE:   dig_s = 2'd0;
      8'hFD:   dig_s = 2'd1;
      8'hFB:   dig_s = 2'd2;
      8'hFF:   blank_s = 1'b1;
      default: illegal_s = 1'b1;
    endcase
  end

  // Frame assembly FSM; bcd is only written once all three digits arrive in order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= WAIT0;
      sh0_r      <= 4'h0;
      sh1_r      <= 4'h0;
      bcd        <= 12'h000;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      seg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      if (clr_err) begin
        seg_err <= 1'b0;
      end
      if (accept_r && !blank_s) begin
        if (illegal_s) begin
          seq_err <= 1'b1;
          state_r <= WAIT0;
        end else begin
          if (dec_s[4]) begin
            seg_err <= 1'b1;
          end
          case (state_r)
            WAIT0: begin
              if (dig_s == 2'd0) begin
                sh0_r   <= dec_s[3:0];
                state_r <= GOT0;
              end else begin
                seq_err <= 1'b1;
              end
            end
            GOT0: begin
              case (dig_s)
                2'd1: begin
                  sh1_r   <= dec_s[3:0];
                  state_r <= GOT1;
                end
                2'd0: begin
                  sh0_r   <= dec_s[3:0];
                  seq_err <= 1'b1;
                end
                default: begin
                  seq_err <= 1'b1;
                  state_r <= WAIT0;
                end
              endcase
            end
            GOT1: begin
              case (dig_s)
                2'd2: begin
                  bcd        <= {dec_s[3:0], sh1_r, sh0_r};
                  frame_done <= 1'b1;
                  valid      <= 1'b1;
                  state_r    <= WAIT0;
                end
                2'd0: begin
                  sh0_r   <= dec_s[3:0];
                  seq_err <= 1'b1;
                  state_r <= GOT0;
                end
                default: begin
                  seq_err <= 1'b1;
                  state_r <= WAIT0;
                end
              endcase
            end
            default: state_r <= WAIT0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scenario bench for seg_scan_decoder: expected frames are queued as scans are driven
// and matched against frames the monitor sees on frame_done.
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        clr_err;
  logic [11:0] bcd;
  logic        valid;
  logic        frame_done;
  logic        seq_err;
  logic        seg_err;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int fd_cnt = 0;
  int se_cnt = 0;
  int pw_bad = 0;
  logic fd_prev = 1'b0;
  logic se_prev = 1'b0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  seg_scan_decoder #(.STABLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .clr_err(clr_err),
    .bcd(bcd), .valid(valid), .frame_done(frame_done), .seq_err(seq_err), .seg_err(seg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe output pulses away from the active edge.
  always @(negedge clk) begin
    if (frame_done) begin
      obs_q.push_back(bcd);
      fd_cnt = fd_cnt + 1;
    end
    if (seq_err) se_cnt = se_cnt + 1;
    if ((frame_done && fd_prev) || (seq_err && se_prev)) pw_bad = pw_bad + 1;
    fd_prev = frame_done;
    se_prev = seq_err;
  end

  task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int d0, input int d1, input int d2, input int n);
    hold(8'hFE, seg_tab[d0], n);
    hold(8'hFD, seg_tab[d1], n);
    hold(8'hFB, seg_tab[d2], n);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bcd); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
    checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL reset_seg_err got %b want 0", seg_err); end
  endtask

  task automatic test_normal;
    int fd0 = fd_cnt;
    int se0 = se_cnt;
    send_frame(3, 5, 1, 20);
    exp_q.push_back(12'h153);
    hold(8'hFF, 7'h7F, 10);
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL normal_fd_count got %0d want 1", fd_cnt - fd0); end
    checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL normal_seq_err got %0d want 0", se_cnt - se0); end
    checks++; if (bcd !== 12'h153) begin errors++; $display("FAIL normal_bcd got %h want 153", bcd); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL normal_valid got %b want 1", valid); end
    checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL normal_seg_err got %b want 0", seg_err); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL normal_frames got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [11:0] o = obs_q.pop_front();
      logic [11:0] e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL normal_frame got %h want %h", o, e); end
    end
  endtask

  task automatic test_glitch;
    int fd0 = fd_cnt;
    int se0 = se_cnt;
    hold(8'hFE, seg_tab[2], 20);
    hold(8'hFD, seg_tab[4], 10);
    hold(8'hFD, seg_tab[8], 3);
    hold(8'hFD, seg_tab[4], 20);
    hold(8'hFB, seg_tab[6], 20);
    hold(8'hFF, 7'h7F, 10);
    checks++; if (se_cnt - se0 != 2) begin errors++; $display("FAIL glitch_seq_err got %0d want 2", se_cnt - se0); end
    checks++; if (fd_cnt - fd0 != 0) begin errors++; $display("FAIL glitch_fd_count got %0d want 0", fd_cnt - fd0); end
    checks++; if (bcd !== 12'h153) begin errors++; $display("FAIL glitch_bcd got %h want 153", bcd); end
    checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL glitch_seg_err got %b want 0", seg_err); end
  endtask

  task automatic test_bad_seg;
    int fd0 = fd_cnt;
    int se0 = se_cnt;
    hold(8'hFE, seg_tab[7], 20);
    hold(8'hFD, 7'b1111111, 20);
    hold(8'hFB, seg_tab[9], 20);
    exp_q.push_back(12'h9F7);
    hold(8'hFF, 7'h7F, 15);
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL badseg_fd_count got %0d want 1", fd_cnt - fd0); end
    checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL badseg_seq_err got %0d want 0", se_cnt - se0); end
    checks++; if (bcd !== 12'h9F7) begin errors++; $display("FAIL badseg_bcd got %h want 9F7", bcd); end
    checks++; if (seg_err !== 1'b1) begin errors++; $display("FAIL badseg_sticky got %b want 1", seg_err); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL badseg_frames got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [11:0] o = obs_q.pop_front();
      logic [11:0] e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL badseg_frame got %h want %h", o, e); end
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL badseg_clear got %b want 0", seg_err); end
  endtask

  task automatic test_out_of_order;
    int fd0 = fd_cnt;
    int se0 = se_cnt;
    hold(8'hFD, seg_tab[1], 20);
    checks++; if (se_cnt - se0 != 1) begin errors++; $display("FAIL ooo_digit1_first got %0d want 1", se_cnt - se0); end
    checks++; if (bcd !== 12'h9F7) begin errors++; $display("FAIL ooo_bcd got %h want 9F7", bcd); end
    hold(8'hFC, seg_tab[0], 20);
    checks++; if (se_cnt - se0 != 2) begin errors++; $display("FAIL ooo_illegal_an got %0d want 2", se_cnt - se0); end
    hold(8'hFE, seg_tab[4], 20);
    hold(8'hFF, 7'h7F, 20);
    hold(8'hFD, seg_tab[2], 20);
    hold(8'hFF, 7'h7F, 20);
    hold(8'hFB, seg_tab[0], 20);
    exp_q.push_back(12'h024);
    hold(8'hFF, 7'h7F, 10);
    checks++; if (se_cnt - se0 != 2) begin errors++; $display("FAIL ooo_blank_gap got %0d want 2", se_cnt - se0); end
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL ooo_fd_count got %0d want 1", fd_cnt - fd0); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ooo_frames got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [11:0] o = obs_q.pop_front();
      logic [11:0] e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL ooo_frame got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int fd0;
    int se0;
    hold(8'hFE, seg_tab[1], 20);
    hold(8'hFD, seg_tab[2], 20);
    hold(8'hFF, 7'h7F, 2);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL midrst_bcd got %h want 000", bcd); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid); end
    checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL midrst_seg_err got %b want 0", seg_err); end
    fd0 = fd_cnt;
    se0 = se_cnt;
    hold(8'hFB, seg_tab[3], 20);
    hold(8'hFF, 7'h7F, 10);
    checks++; if (se_cnt - se0 != 1) begin errors++; $display("FAIL midrst_digit2_seq got %0d want 1", se_cnt - se0); end
    checks++; if (fd_cnt - fd0 != 0) begin errors++; $display("FAIL midrst_digit2_fd got %0d want 0", fd_cnt - fd0); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL midrst_bcd_after got %h want 000", bcd); end
  endtask

  task automatic test_back_to_back;
    int fd0 = fd_cnt;
    int se0 = se_cnt;
    int pw0 = pw_bad;
    logic [11:0] sw_tab [2] = '{12'h907, 12'h042};
    for (int v = 0; v < 2; v++) begin
      logic [11:0] sw = sw_tab[v];
      for (int c = 0; c < 3; c++) begin
        hold(8'hFE, seg_tab[sw[3:0]], 12);
        hold(8'hFD, seg_tab[sw[7:4]], 12);
        hold(8'hFB, seg_tab[sw[11:8]], 12);
        exp_q.push_back(sw);
      end
    end
    hold(8'hFF, 7'h7F, 20);
    checks++; if (fd_cnt - fd0 != 6) begin errors++; $display("FAIL b2b_fd_count got %0d want 6", fd_cnt - fd0); end
    checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL b2b_seq_err got %0d want 0", se_cnt - se0); end
    checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL b2b_seg_err got %b want 0", seg_err); end
    checks++; if (bcd !== 12'h042) begin errors++; $display("FAIL b2b_bcd got %h want 042", bcd); end
    checks++; if (pw_bad != pw0) begin errors++; $display("FAIL b2b_pulse_width got %0d wide pulses want 0", pw_bad - pw0); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_frames got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [11:0] o = obs_q.pop_front();
      logic [11:0] e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_frame got %h want %h", o, e); end
    end
  endtask

  initial begin
    rst     = 1'b0;
    an      = 8'hFF;
    seg     = 7'h7F;
    clr_err = 1'b0;
    @(negedge clk);
    test_reset;
    test_normal;
    test_glitch;
    test_bad_seg;
    test_out_of_order;
    test_reset_mid_frame;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
